evt_debouncer: RTL and testbench
================================

EVT_DEBOUNCER -- requirements
Module: evt_debouncer

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 100_000: consecutive stable synchronized cycles needed to accept a level change; legal range 1..2^20-1.
REQ-002 SHALL have parameter REPEAT_DELAY, default 50_000_000: cycles held after press acceptance before the first auto-repeat pulse; legal range 1..2^27-1.
REQ-003 SHALL have parameter REPEAT_PERIOD, default 10_000_000: cycles between subsequent auto-repeat pulses; legal range 1..2^27-1.
REQ-004 SHALL have port clk_in  input  1  sole clock; all state on rising edge.
REQ-005 SHALL have port rst_in  input  1  reset, asynchronous, active-low.
REQ-006 SHALL have port btn_in  input  1  raw asynchronous button level, active-high, may bounce.
REQ-007 SHALL have port evt_out  output  1  single-cycle press event pulse, drives a downstream event counter's evt_in.
REQ-008 SHALL have port release_out  output  1  single-cycle release event pulse.
REQ-009 SHALL have port level_out  output  1  debounced button level.

Function
REQ-010 SHALL pass btn_in through a 2-flop synchronizer; only the second flop output (sync) feeds the FSM.
REQ-011 SHALL implement FSM states IDLE, PRESS_WAIT, HELD, RELEASE_WAIT with a 20-bit stability counter.
REQ-012 IDLE: sync=1 -> PRESS_WAIT, counter=0; else stay.
REQ-013 PRESS_WAIT: sync=0 -> IDLE, counter cleared, no pulse; sync=1 and counter==DEBOUNCE_CYCLES-1 -> HELD; else counter+1.
REQ-014 HELD: sync=0 -> RELEASE_WAIT, counter=0; else stay.
REQ-015 RELEASE_WAIT: sync=1 -> HELD, counter cleared, no pulse; sync=0 and counter==DEBOUNCE_CYCLES-1 -> IDLE; else counter+1.
REQ-016 evt_out SHALL be high for exactly the one cycle following the PRESS_WAIT->HELD edge; level_out SHALL rise on that same edge.
REQ-017 release_out SHALL be high for exactly the one cycle following the RELEASE_WAIT->IDLE edge; level_out SHALL fall on that same edge.
REQ-018 Latency: btn_in held high from first sampling edge E -> evt_out high in cycle E+1+DEBOUNCE_CYCLES+1 (2 sync + DEBOUNCE_CYCLES debounce); release is symmetric.
REQ-019 level_out SHALL stay 1 throughout RELEASE_WAIT and 0 throughout PRESS_WAIT.
REQ-020 evt_out and release_out SHALL never be high in the same cycle.
REQ-021 DEBOUNCE_CYCLES=1 SHALL accept a change after one stable sync cycle.
REQ-022 Counters SHALL never wrap; each saturates at its compare value and is cleared on state exit.

Reset
REQ-023 rst_in low SHALL immediately force state IDLE, all counters 0, synchronizer flops 0, evt_out=0, release_out=0, level_out=0.
REQ-024 Reset asserted mid-press (any state) SHALL discard progress; after deassertion a held button SHALL require full 2+DEBOUNCE_CYCLES cycles before evt_out.
REQ-025 No evt_out or release_out pulse SHALL be generated by reset assertion or deassertion itself.

Configuration
REQ-026 Macro EVT_DEBOUNCER_AUTO_REPEAT_EN SHALL control auto-repeat.
REQ-027 With the macro defined: in HELD, a 27-bit repeat counter SHALL emit an evt_out pulse REPEAT_DELAY cycles after the press pulse, then every REPEAT_PERIOD cycles while in HELD; the repeat counter SHALL pause (not reset) in RELEASE_WAIT and resume if the glitch returns to HELD; it SHALL clear on entering IDLE.
REQ-028 Without the macro: no repeat counter is synthesized, REPEAT_DELAY/REPEAT_PERIOD are ignored, exactly one evt_out per accepted press.

Verification (DEBOUNCE_CYCLES=4, REPEAT_DELAY=10, REPEAT_PERIOD=3)
REQ-029 Clean press: btn_in 0->1 before edge 0, held -> evt_out high only in cycle 6, level_out 1 from cycle 6.
REQ-030 Bounce: btn_in 1 for 3 cycles, 0 for 1, then 1 steady -> no pulse during bounce; single evt_out 6 cycles after final rise.
REQ-031 Release glitch: held, btn_in 0 for 2 cycles then 1 -> no release_out, level_out stays 1; later steady 0 -> one release_out 6 cycles after fall.
REQ-032 Reset mid-debounce: rst_in low in PRESS_WAIT with counter=2, released with btn_in still 1 -> all outputs 0, evt_out 6 cycles after deassertion.
REQ-033 Auto-repeat (macro defined): hold 30 cycles after press pulse at cycle P -> evt_out at P, P+10, P+13, P+16, ..., P+28; macro undefined -> only at P.

Source files
------------

// File: rtl/evt_debouncer.sv
// Button debouncer: 2-flop synchronizer plus a four-state stability FSM that emits
// single-cycle press/release pulses. Define EVT_DEBOUNCER_AUTO_REPEAT_EN for auto-repeat while held.
module evt_debouncer #(
    parameter int unsigned DEBOUNCE_CYCLES = 100_000,
    parameter int unsigned REPEAT_DELAY    = 50_000_000,
    parameter int unsigned REPEAT_PERIOD   = 10_000_000
) (
    input  logic clk_in,
    input  logic rst_in,
    input  logic btn_in,
    output logic evt_out,
    output logic release_out,
    output logic level_out
);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_WAIT,
        HELD,
        RELEASE_WAIT
    } state_t;

    localparam logic [19:0] DEB_LAST = 20'(DEBOUNCE_CYCLES - 1);

    state_t      state_q, state_d;
    logic [19:0] cnt_q, cnt_d;
    logic        sync1_q, sync2_q;
    logic        evt_q, evt_d;
    logic        rel_q, rel_d;
    logic        level_q, level_d;
    logic        press_acc;
    logic        rep_fire;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            state_q <= IDLE;
            cnt_q   <= '0;
            evt_q   <= 1'b0;
            rel_q   <= 1'b0;
            level_q <= 1'b0;
        end else begin
            sync1_q <= btn_in;
            sync2_q <= sync1_q;
            state_q <= state_d;
            cnt_q   <= cnt_d;
            evt_q   <= evt_d;
            rel_q   <= rel_d;
            level_q <= level_d;
        end
    end

    // Any disagreement with the candidate level during a wait state abandons it without a pulse.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rel_d     = 1'b0;
        level_d   = level_q;
        press_acc = 1'b0;
        case (state_q)
            IDLE: begin
                if (sync2_q) begin
                    state_d = PRESS_WAIT;
                    cnt_d   = '0;
                end
            end
            PRESS_WAIT: begin
                if (!sync2_q) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d   = HELD;
                    cnt_d     = '0;
                    press_acc = 1'b1;
                    level_d   = 1'b1;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            HELD: begin
                if (!sync2_q) begin
                    state_d = RELEASE_WAIT;
                    cnt_d   = '0;
                end
            end
            RELEASE_WAIT: begin
                if (sync2_q) begin
                    state_d = HELD;
                    cnt_d   = '0;
                end else if (cnt_q == DEB_LAST) begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    rel_d   = 1'b1;
                    level_d = 1'b0;
                end else begin
                    cnt_d = cnt_q + 20'd1;
                end
            end
            default: begin
                state_d = IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    assign evt_d = press_acc | rep_fire;

`ifdef EVT_DEBOUNCER_AUTO_REPEAT_EN
    localparam logic [26:0] DELAY_LAST  = 27'(REPEAT_DELAY - 1);
    localparam logic [26:0] PERIOD_LAST = 27'(REPEAT_PERIOD - 1);

    logic [26:0] rep_q, rep_d;
    logic        armed_q, armed_d;

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            rep_q   <= '0;
            armed_q <= 1'b0;
        end else begin
            rep_q   <= rep_d;
            armed_q <= armed_d;
        end
    end

    // Counts only while HELD stays HELD; a release glitch freezes it so repeat timing resumes.
    always_comb begin
        rep_d    = rep_q;
        armed_d  = armed_q;
        rep_fire = 1'b0;
        if (state_d == IDLE || state_d == PRESS_WAIT) begin
            rep_d   = '0;
            armed_d = 1'b0;
        end else if (state_q == HELD && sync2_q) begin
            if (rep_q == (armed_q ? PERIOD_LAST : DELAY_LAST)) begin
                rep_fire = 1'b1;
                rep_d    = '0;
                armed_d  = 1'b1;
            end else begin
                rep_d = rep_q + 27'd1;
            end
        end
    end
`else
    logic unused_repeat_cfg;

    assign unused_repeat_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
    assign rep_fire          = 1'b0;
`endif

    assign evt_out     = evt_q;
    assign release_out = rel_q;
    assign level_out   = level_q;

endmodule

// File: tb/tb_evt_debouncer.sv
// Self-checking bench for evt_debouncer: directed press/bounce/glitch/reset scenarios
// followed by random button traffic, all compared against a run-length reference model.
module tb_evt_debouncer;

    localparam int DEB = 4;
    localparam int RD  = 10;
    localparam int RP  = 3;
`ifdef EVT_DEBOUNCER_AUTO_REPEAT_EN
    localparam bit AR = 1'b1;
`else
    localparam bit AR = 1'b0;
`endif

    logic clk_in = 1'b0;
    logic rst_in;
    logic btn_in;
    logic evt_out;
    logic release_out;
    logic level_out;

    int total = 0;
    int bad   = 0;

    // Reference model state: btn history, current run of equal sync values, accepted level.
    logic h1, h2, runVal, prevSync, modelLevel, expEvt, expRel;
    int   runLen, holdN;

    evt_debouncer #(
        .DEBOUNCE_CYCLES(DEB),
        .REPEAT_DELAY   (RD),
        .REPEAT_PERIOD  (RP)
    ) dut (
        .clk_in     (clk_in),
        .rst_in     (rst_in),
        .btn_in     (btn_in),
        .evt_out    (evt_out),
        .release_out(release_out),
        .level_out  (level_out)
    );

    always #5 clk_in = ~clk_in;

    task automatic modelReset();
        h1 = 1'b0; h2 = 1'b0; runVal = 1'b0; runLen = 0; prevSync = 1'b0;
        modelLevel = 1'b0; expEvt = 1'b0; expRel = 1'b0; holdN = 0;
    endtask

    // A level is accepted once the synchronized value has been stable for DEB+1 edges.
    task automatic modelStep(input logic b);
        logic syncNow;
        syncNow = h2;
        h2 = h1;
        h1 = b;
        expEvt = 1'b0;
        expRel = 1'b0;
        if (syncNow == runVal) runLen++;
        else begin
            runVal = syncNow;
            runLen = 1;
        end
        if (!modelLevel) begin
            if (runVal && runLen == DEB + 1) begin
                expEvt = 1'b1;
                modelLevel = 1'b1;
                holdN = 0;
            end
        end else begin
            if (prevSync && syncNow) begin
                holdN++;
                if (AR && holdN >= RD && ((holdN - RD) % RP) == 0) expEvt = 1'b1;
            end
            if (!runVal && runLen == DEB + 1) begin
                expRel = 1'b1;
                modelLevel = 1'b0;
                holdN = 0;
            end
        end
        prevSync = syncNow;
    endtask

    task automatic checkBit(input string tag, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic checkInt(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic checkOutput();
        checkBit("evt_out", evt_out, expEvt);
        checkBit("release_out", release_out, expRel);
        checkBit("level_out", level_out, modelLevel);
        checkBit("evt_rel_exclusive", evt_out & release_out, 1'b0);
    endtask

    task automatic applyStimulus(input logic b);
        btn_in = b;
        @(posedge clk_in);
        if (!rst_in) modelReset();
        else modelStep(b);
        #1;
        checkOutput();
    endtask

    task automatic pulseReset(input logic b);
        #2 rst_in = 1'b0;
        modelReset();
        #1;
        checkOutput();
        applyStimulus(b);
        #2 rst_in = 1'b1;
    endtask

    initial begin
        int evtAt, relAt, nEvt, nRel, len;
        logic b;

        rst_in = 1'b0;
        btn_in = 1'b0;
        modelReset();
        repeat (3) applyStimulus(1'b0);
        #2 rst_in = 1'b1;
        repeat (3) applyStimulus(1'b0);

        // Clean press held long enough to cover the auto-repeat window.
        evtAt = -1; nEvt = 0;
        for (int k = 0; k <= 36; k++) begin
            applyStimulus(1'b1);
            if (evt_out) begin
                nEvt++;
                if (evtAt < 0) evtAt = k;
            end
        end
        checkInt("press_latency", evtAt, 6);
        checkInt("press_pulse_count", nEvt, AR ? 8 : 1);

        // Short release glitch must not be accepted.
        nRel = 0;
        for (int k = 0; k < 10; k++) begin
            applyStimulus((k < 2) ? 1'b0 : 1'b1);
            if (release_out) nRel++;
        end
        checkInt("glitch_release_count", nRel, 0);
        checkBit("glitch_level", level_out, 1'b1);

        relAt = -1; nRel = 0;
        for (int k = 0; k < 12; k++) begin
            applyStimulus(1'b0);
            if (release_out) begin
                nRel++;
                if (relAt < 0) relAt = k;
            end
        end
        checkInt("release_latency", relAt, 6);
        checkInt("release_pulse_count", nRel, 1);

        // Bounce: three high, one low, then steady high.
        nEvt = 0;
        for (int k = 0; k < 4; k++) begin
            applyStimulus((k < 3) ? 1'b1 : 1'b0);
            if (evt_out) nEvt++;
        end
        checkInt("bounce_no_pulse", nEvt, 0);
        evtAt = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1);
            if (evt_out && evtAt < 0) evtAt = k;
        end
        checkInt("bounce_latency", evtAt, 6);
        repeat (10) applyStimulus(1'b0);

        // Reset while the press counter sits at 2, button still held afterwards.
        repeat (5) applyStimulus(1'b1);
        pulseReset(1'b1);
        checkBit("reset_level", level_out, 1'b0);
        evtAt = -1;
        for (int k = 0; k < 10; k++) begin
            applyStimulus(1'b1);
            if (evt_out && evtAt < 0) evtAt = k;
        end
        checkInt("reset_press_latency", evtAt, 6);
        repeat (10) applyStimulus(1'b0);

        // Random traffic: mostly short runs, some long holds, occasional resets.
        for (int r = 0; r < 120; r++) begin
            b = 1'($urandom_range(0, 1));
            len = ($urandom_range(0, 5) == 0) ? $urandom_range(8, 40) : $urandom_range(1, 7);
            if ($urandom_range(0, 29) == 0) pulseReset(b);
            for (int k = 0; k < len; k++) applyStimulus(b);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
